onchip_mem_copy_master: RTL and testbench

Avalon-MM initiator that drives the single-port on-chip memory slave of the Nios2Computer system (32-bit words, 5120-word depth, fixed 1-cycle read latency, no waitrequest). It executes block-copy and block-fill jobs on that memory from a simple start/done control port. This offloads memory initialisation and buffer moves from the Nios II. It sits beside the CPU data master as a second initiator into the memory's s2 port.

---
 rtl/onchip_mem_copy_pkg.sv | 9 +
 rtl/onchip_mem_range_check.sv | 21 ++
 rtl/onchip_mem_copy_master.sv | 101 ++++++++++
 tb/tb_onchip_mem_copy_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_copy_pkg.sv
// onchip_mem_copy_pkg: shared state encoding, mode constants and default sizes for the memory copy master
package onchip_mem_copy_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, READ, CAPTURE, WRITE, DONE} state_t;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 5120;
endpackage

// File: rtl/onchip_mem_range_check.sv
// onchip_mem_range_check: job bounds check and copy-direction decision
module onchip_mem_range_check
  import onchip_mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] length,
  output logic              err,
  output logic              desc
);
  logic [ADDR_W:0] src_end, dst_end;
  assign src_end = {1'b0, src} + {1'b0, length};
  assign dst_end = {1'b0, dst} + {1'b0, length};
  assign err = dst_end > (ADDR_W+1)'(DEPTH) || (mode == MODE_COPY && src_end > (ADDR_W+1)'(DEPTH));
  // overlapping forward copy must run top-down so source words are read before being overwritten
  assign desc = mode == MODE_COPY && src < dst && {1'b0, dst} < src_end;
endmodule

// File: rtl/onchip_mem_copy_master.sv
// onchip_mem_copy_master: Avalon-MM initiator running block copy and fill jobs on a 1-cycle-latency on-chip memory
module onchip_mem_copy_master
  import onchip_mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              avm_clken
);
  state_t state, state_n;
  logic mode_q, desc_q, err_q, range_err, desc;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, src_ptr, dst_ptr, cnt;
  logic [DATA_W-1:0] fill_q, data_q;

  onchip_mem_range_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_range (
    .mode(mode_q), .src(src_q), .dst(dst_q), .length(len_q), .err(range_err), .desc(desc)
  );

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (!pause) state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CHECK : IDLE;
      CHECK:   state_n = (range_err || len_q == '0) ? DONE : mode_q == MODE_FILL ? WRITE : READ;
      READ:    state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = cnt == ADDR_W'(1) ? DONE : mode_q == MODE_FILL ? WRITE : READ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_COPY;
      desc_q <= 1'b0;
      err_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      fill_q <= '0;
      data_q <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt <= '0;
    end else if (!pause) begin
      if (state == IDLE && start) begin
        mode_q <= mode;
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= length;
        fill_q <= fill_data;
        err_q <= 1'b0;
      end
      if (state == CHECK) begin
        err_q <= range_err;
        desc_q <= desc;
        cnt <= len_q;
        src_ptr <= desc ? src_q + len_q - ADDR_W'(1) : src_q;
        dst_ptr <= desc ? dst_q + len_q - ADDR_W'(1) : dst_q;
      end
      if (state == CAPTURE) data_q <= avm_readdata;
      if (state == WRITE) begin
        src_ptr <= desc_q ? src_ptr - ADDR_W'(1) : src_ptr + ADDR_W'(1);
        dst_ptr <= desc_q ? dst_ptr - ADDR_W'(1) : dst_ptr + ADDR_W'(1);
        cnt <= cnt - ADDR_W'(1);
      end
    end
  end

  assign busy = state != IDLE;
  assign done = state == DONE;
  assign error = err_q;
  assign avm_chipselect = state == READ || state == WRITE;
  assign avm_write = state == WRITE;
  assign avm_address = state == READ ? src_ptr : dst_ptr;
  assign avm_writedata = mode_q == MODE_FILL ? fill_q : data_q;
  assign avm_byteenable = 4'b1111;
  assign avm_clken = ~pause;
endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// tb_onchip_mem_copy_master: scenario tasks plus randomized jobs checked against a memmove/fill reference model
module tb_onchip_mem_copy_master;
  import onchip_mem_copy_pkg::*;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DEPTH = 5120;

  logic clk = 1'b0;
  logic reset, start, mode, pause;
  logic [AW-1:0] src_addr, dst_addr, length;
  logic [DW-1:0] fill_data;
  logic busy, done, error, avm_chipselect, avm_write, avm_clken;
  logic [AW-1:0] avm_address;
  logic [3:0] avm_byteenable;
  logic [DW-1:0] avm_writedata, avm_readdata;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int cyc = 0;
  int bus_log[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_data(fill_data), .pause(pause),
    .busy(busy), .done(done), .error(error), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_clken(avm_clken)
  );

  // memory slave with 1-cycle read latency; every accepted bus cycle is logged as {write, address}
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_clken && avm_chipselect) begin
      bus_log.push_back(int'({avm_write, avm_address}));
      if (avm_write) mem[avm_address] <= avm_writedata;
      else avm_readdata <= mem[avm_address];
    end
  end

  function automatic int enc(input bit w, input int a);
    return (w ? 8192 : 0) + a;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic model_job(input logic m, input int s, input int d, input int l, input logic [31:0] f,
                           output int lat, output logic e, output int nbus);
    logic [31:0] tmp[$];
    e = (d + l > DEPTH) || (m == MODE_COPY && s + l > DEPTH);
    lat = (e || l == 0) ? 2 : (m == MODE_COPY ? 2 + 3 * l : 2 + l);
    nbus = (e || l == 0) ? 0 : (m == MODE_COPY ? 2 * l : l);
    if (!e) begin
      for (int i = 0; i < l; i++) tmp.push_back(m == MODE_COPY ? ref_mem[s + i] : f);
      for (int i = 0; i < l; i++) ref_mem[d + i] = tmp[i];
    end
  endtask

  task automatic launch(input logic m, input int s, input int d, input int l, input logic [31:0] f,
                        output int c0, output int b0);
    @(negedge clk);
    mode = m; src_addr = AW'(s); dst_addr = AW'(d); length = AW'(l); fill_data = f;
    start = 1'b1; c0 = cyc; b0 = bus_log.size();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat, output logic e);
    lat = -1; e = 1'bx;
    for (int i = 0; i < 6000 && lat < 0; i++)
      if (done) begin lat = cyc - c0; e = error; end
      else @(negedge clk);
  endtask

  task automatic run_job(input logic m, input int s, input int d, input int l, input logic [31:0] f,
                         output int lat, output logic e, output int nbus, output int b0);
    int c0;
    launch(m, s, d, l, f, c0, b0);
    wait_done(c0, lat, e);
    nbus = bus_log.size() - b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({busy, done, error, avm_chipselect, avm_write} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {busy, done, error, avm_chipselect, avm_write}); else passed++;
    total++; if (avm_address !== '0) $display("FAIL reset_address got %0h want 0", avm_address); else passed++;
    total++; if (avm_writedata !== '0) $display("FAIL reset_writedata got %0h want 0", avm_writedata); else passed++;
    total++; if (avm_byteenable !== 4'hf || avm_clken !== 1'b1) $display("FAIL reset_be_clken got %h/%b want f/1", avm_byteenable, avm_clken); else passed++;
  endtask

  task automatic test_fill_all();
    int lat, elat, nb, enb, b0; logic e, ee;
    model_job(MODE_FILL, 0, 0, DEPTH, 32'hDEADBEEF, elat, ee, enb);
    run_job(MODE_FILL, 0, 0, DEPTH, 32'hDEADBEEF, lat, e, nb, b0);
    total++; if (lat !== 5122) $display("FAIL fill_latency got %0d want 5122", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL fill_error got %b want 0", e); else passed++;
    total++; if (nb !== DEPTH) $display("FAIL fill_bus_cycles got %0d want %0d", nb, DEPTH); else passed++;
    total++; if (mem_diffs() !== 0) $display("FAIL fill_contents got %0d bad words want 0", mem_diffs()); else passed++;
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    int lat, elat, nb, enb, b0; logic e, ee;
    model_job(MODE_FILL, 0, a, 1, v, elat, ee, enb);
    run_job(MODE_FILL, 0, a, 1, v, lat, e, nb, b0);
    total++; if (lat !== elat || mem[a] !== v) $display("FAIL preload_%0h got lat %0d data %0h want lat %0d data %0h", a, lat, mem[a], elat, v); else passed++;
  endtask

  task automatic test_copy();
    int lat, elat, nb, enb, b0, bad; logic e, ee; int exp_log[$], got_log[$];
    for (int i = 0; i < 4; i++) preload(16 + i, 32'hA0 + i);
    model_job(MODE_COPY, 16, 256, 4, 0, elat, ee, enb);
    run_job(MODE_COPY, 16, 256, 4, 0, lat, e, nb, b0);
    total++; if (lat !== 14) $display("FAIL copy_latency got %0d want 14", lat); else passed++;
    for (int i = 0; i < 4; i++) begin exp_log.push_back(enc(0, 16 + i)); exp_log.push_back(enc(1, 256 + i)); end
    for (int i = b0; i < bus_log.size(); i++) got_log.push_back(bus_log[i]);
    total++; if (got_log != exp_log) $display("FAIL copy_bus_order got %p want %p", got_log, exp_log); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[256 + i] !== 32'hA0 + i) bad++;
    total++; if (bad !== 0 || mem_diffs() !== 0) $display("FAIL copy_contents got %0d/%0d bad want 0", bad, mem_diffs()); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL copy_busy_fall got busy %b done %b want 0 0", busy, done); else passed++;
  endtask

  task automatic test_overlap();
    int lat, elat, nb, enb, b0, bad; logic e, ee;
    for (int i = 0; i < 4; i++) preload(32 + i, i + 1);
    model_job(MODE_COPY, 32, 34, 4, 0, elat, ee, enb);
    run_job(MODE_COPY, 32, 34, 4, 0, lat, e, nb, b0);
    total++; if (bus_log[b0 + 1] !== enc(1, 37)) $display("FAIL overlap_first_write got %0h want %0h", bus_log[b0 + 1], enc(1, 37)); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[34 + i] !== i + 1) bad++;
    total++; if (bad !== 0 || mem_diffs() !== 0) $display("FAIL overlap_contents got %0d/%0d bad want 0", bad, mem_diffs()); else passed++;
    total++; if (lat !== 14) $display("FAIL overlap_latency got %0d want 14", lat); else passed++;
  endtask

  task automatic test_range_error();
    int lat, elat, nb, enb, b0; logic e, ee;
    model_job(MODE_FILL, 0, 5118, 3, 32'h1, elat, ee, enb);
    run_job(MODE_FILL, 0, 5118, 3, 32'h1, lat, e, nb, b0);
    total++; if (lat !== 2 || e !== 1'b1) $display("FAIL range_dst got lat %0d err %b want 2 1", lat, e); else passed++;
    total++; if (nb !== 0) $display("FAIL range_bus got %0d want 0", nb); else passed++;
    @(negedge clk);
    total++; if (error !== 1'b1) $display("FAIL range_error_hold got %b want 1", error); else passed++;
    model_job(MODE_COPY, 5118, 0, 3, 0, elat, ee, enb);
    run_job(MODE_COPY, 5118, 0, 3, 0, lat, e, nb, b0);
    total++; if (lat !== 2 || e !== 1'b1 || nb !== 0) $display("FAIL range_src got lat %0d err %b bus %0d want 2 1 0", lat, e, nb); else passed++;
    model_job(MODE_FILL, 5119, 5117, 3, 32'h55AA, elat, ee, enb);
    run_job(MODE_FILL, 5119, 5117, 3, 32'h55AA, lat, e, nb, b0);
    total++; if (lat !== 5 || e !== 1'b0 || nb !== 3) $display("FAIL range_edge_clear got lat %0d err %b bus %0d want 5 0 3", lat, e, nb); else passed++;
    total++; if (mem_diffs() !== 0) $display("FAIL range_contents got %0d bad want 0", mem_diffs()); else passed++;
  endtask

  task automatic test_zero_and_busy_start();
    int lat, elat, nb, enb, b0, c0; logic e, ee;
    model_job(MODE_COPY, 5, 9, 0, 0, elat, ee, enb);
    run_job(MODE_COPY, 5, 9, 0, 0, lat, e, nb, b0);
    total++; if (lat !== 2 || e !== 1'b0 || nb !== 0) $display("FAIL zero_len got lat %0d err %b bus %0d want 2 0 0", lat, e, nb); else passed++;
    model_job(MODE_FILL, 0, 768, 6, 32'h12345678, elat, ee, enb);
    launch(MODE_FILL, 0, 768, 6, 32'h12345678, c0, b0);
    @(negedge clk); @(negedge clk);
    mode = MODE_COPY; src_addr = AW'(0); dst_addr = AW'(1024); length = AW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c0, lat, e);
    total++; if (lat !== 8 || bus_log.size() - b0 !== 6) $display("FAIL busy_start got lat %0d bus %0d want 8 6", lat, bus_log.size() - b0); else passed++;
    total++; if (mem_diffs() !== 0) $display("FAIL busy_start_contents got %0d bad want 0", mem_diffs()); else passed++;
  endtask

  task automatic test_pause();
    int lat, elat, nb, enb, b0, c0; logic e, ee;
    model_job(MODE_COPY, 256, 512, 4, 0, elat, ee, enb);
    launch(MODE_COPY, 256, 512, 4, 0, c0, b0);
    @(negedge clk); @(negedge clk);
    pause = 1'b1;
    #1;
    total++; if (avm_clken !== 1'b0) $display("FAIL pause_clken got %b want 0", avm_clken); else passed++;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    wait_done(c0, lat, e);
    total++; if (lat !== elat + 3) $display("FAIL pause_latency got %0d want %0d", lat, elat + 3); else passed++;
    total++; if (mem_diffs() !== 0) $display("FAIL pause_contents got %0d bad want 0", mem_diffs()); else passed++;
  endtask

  task automatic test_reset_mid_job();
    int c0, b0; logic [31:0] old1;
    old1 = ref_mem[641];
    launch(MODE_COPY, 256, 640, 4, 0, c0, b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({busy, done, error, avm_chipselect, avm_write} !== 5'b0 || avm_address !== '0 || avm_writedata !== '0)
      $display("FAIL midjob_reset_outputs got %b addr %0h wd %0h want 00000 0 0", {busy, done, error, avm_chipselect, avm_write}, avm_address, avm_writedata); else passed++;
    reset = 1'b0;
    ref_mem[640] = ref_mem[256];
    total++; if (mem[640] !== 32'hA0 || mem[641] !== old1) $display("FAIL midjob_partial got %0h %0h want a0 %0h", mem[640], mem[641], old1); else passed++;
    total++; if (mem_diffs() !== 0) $display("FAIL midjob_contents got %0d bad want 0", mem_diffs()); else passed++;
  endtask

  task automatic test_random();
    int lat, elat, nb, enb, b0, s, d, l; logic e, ee, m; logic [31:0] f;
    for (int k = 0; k < 25; k++) begin
      m = 1'($urandom_range(0, 1));
      l = $urandom_range(0, 12);
      s = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 3))
        0: d = (s + $urandom_range(0, 6) + DEPTH - 3) % DEPTH;
        1: d = DEPTH - $urandom_range(1, 12);
        default: d = $urandom_range(0, DEPTH - 1);
      endcase
      f = $urandom;
      model_job(m, s, d, l, f, elat, ee, enb);
      run_job(m, s, d, l, f, lat, e, nb, b0);
      total++; if (lat !== elat) $display("FAIL rand%0d_latency got %0d want %0d", k, lat, elat); else passed++;
      total++; if (e !== ee) $display("FAIL rand%0d_error got %b want %b", k, e, ee); else passed++;
      total++; if (nb !== enb) $display("FAIL rand%0d_bus got %0d want %0d", k, nb, enb); else passed++;
      total++; if (mem_diffs() !== 0) $display("FAIL rand%0d_contents got %0d bad want 0", k, mem_diffs()); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; pause = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_fill_all();
    test_copy();
    test_overlap();
    test_range_error();
    test_zero_and_busy_start();
    test_pause();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
